// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MIPS MEM-stage load/store front-end with sub-word RMW onto word-addressed datamemory
module mem_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic              mem_we,
  input  logic [31:0]       mem_data_out
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] RWAIT = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;
  logic [2:0]  state;
  logic        r_we;
  logic        r_sgn;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic        err;
  logic [4:0]  sh;
  logic [15:0] lane_data;
  logic [31:0] mask;
  logic [31:0] load_val;
  logic [31:0] merged;
  assign req_ready = state == IDLE;
  always_comb begin
    err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
          (req_size == 2'b10 && req_addr[1:0] != 2'b00) || |req_addr[31:ADDR_W+2];
    sh = {r_lane, 3'b000};
    lane_data = 16'(mem_data_out >> sh);
    mask = (r_size == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    load_val = r_size == 2'b00 ? {{24{r_sgn & lane_data[7]}}, lane_data[7:0]} :
               r_size == 2'b01 ? {{16{r_sgn & lane_data[15]}}, lane_data} : mem_data_out;
    merged = (mem_data_out & ~mask) | ((r_wdata << sh) & mask);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      r_we        <= 1'b0;
      r_sgn       <= 1'b0;
      r_size      <= '0;
      r_lane      <= '0;
      r_wdata     <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_sgn   <= req_signed;
          r_size  <= req_size;
          r_lane  <= req_addr[1:0];
          r_wdata <= req_wdata;
          if (err) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            mem_address <= req_addr[ADDR_W+1:2];
            if (req_we && req_size == 2'b10) begin
              state       <= WRITE;
              mem_we      <= 1'b1;
              mem_data_in <= req_wdata;
            end else begin
              state <= READ;
            end
          end
        end
        READ: state <= RWAIT;
        RWAIT: if (r_we) begin
          state       <= WRITE;
          mem_we      <= 1'b1;
          mem_data_in <= merged;
        end else begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= load_val;
        end
        WRITE: begin
          state      <= RESP;
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
